lsu_master: RTL and testbench
=============================

# lsu_master

Load/store initiator that sits between the core's memory stage and the word-organised data memory. It accepts byte, halfword and word requests at any byte address. It converts each request into one or two word accesses on the memory's async-read / sync-write port, doing read-modify-write merges for stores. Loads return the data right-aligned, sign-extended or zero-extended. Completion is reported to the core through a valid/ready request and single-cycle response handshake.

## Interface
- ALLOW_MISALIGNED, default 1: 1 = split accesses that cross a word boundary into two memory cycles; 0 = reject them with an error.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse, for loads and stores
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; illegal size, or misaligned with ALLOW_MISALIGNED=0
- dm_en  out  1  memory write enable
- dm_addr  out  32  memory byte address, always word-aligned (bits [1:0] = 00)
- dm_wdata  out  32  full merged word to write
- dm_rdata  in  32  memory read data, combinational from dm_addr

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - ACC0: first word.
  - ACC1: second word.
  - RESP: resp_valid=1.
- Acceptance: a request is accepted when req_valid && req_ready at a clk edge. All req_* fields are latched at that edge. req_* is ignored outside IDLE.
- Request decode:
  - off = addr[1:0]; nbytes = 1/2/4 by size.
  - span = (off + nbytes > 4).
  - w0 = addr[31:2]; w1 = w0 + 1, modulo 2^30, so 0x3FFFFFFF wraps to 0.
- IDLE → ACC0 on acceptance, except:
  - size=11: go directly to RESP with err=1, no memory access.
  - span with ALLOW_MISALIGNED=0: go directly to RESP with err=1, no memory access.
- ACC0:
  - dm_addr = {w0, 2'b00}.
  - Byte lanes off .. min(3, off+nbytes-1) hold the low-order request bytes.
  - Store: dm_wdata = dm_rdata with those lanes replaced by wdata bytes, little-endian; dm_en=1.
  - Load: capture those lanes into the result register.
  - Next state: ACC1 if span, else RESP.
- ACC1:
  - dm_addr = {w1, 2'b00}.
  - Lanes 0 .. (off+nbytes-5) carry the remaining high-order bytes, with the same merge/capture rule as ACC0.
  - Next state: RESP.
- RESP:
  - resp_valid=1.
  - resp_rdata = the assembled value extended to 32 bits: bit 7 (byte) or bit 15 (halfword) replicated unless unsigned. Word results are passed through unchanged.
  - Next state: IDLE unconditionally. The core must accept the response; there is no backpressure.
- dm_en is asserted only for stores in ACC0/ACC1 and is forced to 0 while rst=1.
- No combinational path from req_* to dm_* or resp_*: dm_* depend only on state, latched request and dm_rdata.
- Untouched byte lanes of a memory word are written back unchanged.

## Timing
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_en=0, dm_addr=0, dm_wdata=0.
- rst asserted in any state aborts the operation:
  - any in-flight ACC store is suppressed;
  - any pending response is dropped;
  - IDLE from the next cycle.
- Latency from the accept edge to resp_valid:
  - single-word access: 2 cycles (ACC0, RESP);
  - spanning access: 3 cycles;
  - error: 1 cycle.
- Throughput: one request per 3 cycles single-word, 4 cycles spanning. req_ready is low from the cycle after acceptance through RESP.
- Stores commit at the clk edge that ends ACC0 (and ACC1). Memory contents are updated by the time resp_valid is seen.
- A back-to-back load to a just-stored address, accepted in the cycle after RESP, sees the new data.

## Test plan
- Word store addr 0x10, wdata 0xDEADBEEF; then word load 0x10 → resp_rdata 0xDEADBEEF, err 0; resp_valid 2 cycles after each accept.
- Mem[0x20]=0x11223344; byte store 0xAA to 0x21 → word 0x1122AA44. Signed byte load 0x21 → 0xFFFFFFAA. Unsigned byte load 0x21 → 0x000000AA.
- Mem[0x30]=0x00000000, mem[0x34]=0x00000000; word store 0xA1B2C3D4 to 0x33 (ALLOW_MISALIGNED=1) → mem[0x30]=0xD4000000, mem[0x34]=0x00A1B2C3, dm_en high for exactly 2 cycles. Word load 0x33 → 0xA1B2C3D4, resp after 3 cycles.
- req_size=11, or halfword at 0x0003 with ALLOW_MISALIGNED=0 → resp_valid with resp_err=1 one cycle after accept, dm_en never asserted, memory unchanged.
- Halfword load at 0xFFFFFFFF spanning a word boundary → second access dm_addr=0x00000000 (wrap); result {mem[0][7:0], mem[0x3FFFFFFF word][31:24]} sign-extended.
- Store accepted, then rst asserted during ACC0 → dm_en=0 that cycle, no resp_valid, req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/lsu_master.sv
// ---------------------------------------------------------------------------
// lsu_master
//   Load/store initiator between the core memory stage and a word-organised
//   data memory with an async-read / sync-write port. Each byte, halfword or
//   word request at any byte address becomes one or two word accesses.
//   Stores are read-modify-write merges of the addressed byte lanes; loads are
//   assembled, right-aligned and sign- or zero-extended.
//
//   Parameters
//     ALLOW_MISALIGNED  1: split word-crossing accesses over two memory
//                          cycles; 0: answer them with resp_err.
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     req_valid/ready     request handshake (ready only in IDLE)
//     req_we              1 = store, 0 = load
//     req_size            00 byte, 01 halfword, 10 word, 11 illegal
//     req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//     req_addr            byte address
//     req_wdata           right-aligned store data
//     resp_valid          one-cycle completion pulse
//     resp_rdata          extended load result (0 for stores and errors)
//     resp_err            illegal size or rejected misaligned access
//     dm_en               memory write enable
//     dm_addr             word-aligned memory byte address
//     dm_wdata            merged word to write
//     dm_rdata            memory read data, combinational from dm_addr
// ---------------------------------------------------------------------------
module lsu_master #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_en,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, state_nxt;

  // Request fields captured at the accept edge; nothing downstream looks at
  // req_* directly, so dm_* and resp_* have no combinational path from them.
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        span_q;
  logic        err_q;
  logic [31:0] rdata_q;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Decode of the incoming request, used only to pick the next state and to
  // load the capture registers.
  logic req_span;
  logic req_bad;

  assign req_span = ({2'b00, req_addr[1:0]} + {1'b0, size_bytes(req_size)}) > 4'd4;
  assign req_bad  = (req_size == 2'b11) || (req_span && !ALLOW_MISALIGNED);

  // Per-lane mapping for the current access. lane_pos is the request byte
  // index that lane i carries: i - off in ACC0, i + 4 - off in ACC1. Lanes
  // below off in ACC0 wrap to a large value and fall out of the range test.
  logic [2:0] nb_q;
  logic       in_acc;
  logic [3:0] lane_pos [4];
  logic [3:0] lane_act;

  assign nb_q   = size_bytes(size_q);
  assign in_acc = (state == ACC0) || (state == ACC1);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_pos[i] = 4'(i) + ((state == ACC1) ? 4'd4 : 4'd0) - {2'b00, addr_q[1:0]};
      lane_act[i] = in_acc && (lane_pos[i] < {1'b0, nb_q});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output and next-state variable gets a default before the case
  // so that no path leaves one unassigned and a latch is inferred.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    dm_en      = 1'b0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? RESP : ACC0;
      end
      ACC0: begin
        dm_addr   = {addr_q[31:2], 2'b00};
        state_nxt = span_q ? ACC1 : RESP;
      end
      ACC1: begin
        // Second word wraps modulo 2^30 words at the top of the address space.
        dm_addr   = {addr_q[31:2] + 30'd1, 2'b00};
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = !rst;
        resp_err   = !rst && err_q;
        if (!rst && !err_q && !we_q) begin
          case (size_q)
            2'b00:   resp_rdata = {{24{rdata_q[7]  & ~uns_q}}, rdata_q[7:0]};
            2'b01:   resp_rdata = {{16{rdata_q[15] & ~uns_q}}, rdata_q[15:0]};
            default: resp_rdata = rdata_q;
          endcase
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Store merge: untouched lanes are written back exactly as read.
    if (in_acc && we_q) begin
      dm_en    = !rst;
      dm_wdata = dm_rdata;
      for (int i = 0; i < 4; i++) begin
        if (lane_act[i]) dm_wdata[8*i +: 8] = wdata_q[{lane_pos[i][1:0], 3'b000} +: 8];
      end
    end
  end

  // NOTE: the capture registers are cleared on reset only so the bench and
  // waveforms show clean values; function never depends on their reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      span_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        span_q  <= req_span;
        err_q   <= req_bad;
        rdata_q <= 32'h0;
      end
      if (in_acc && !we_q) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_act[i]) rdata_q[{lane_pos[i][1:0], 3'b000} +: 8] <= dm_rdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_master
//   Directed bench for lsu_master. A 64-word memory model (indexed by
//   dm_addr[7:2]) backs the main instance; a second instance built with
//   ALLOW_MISALIGNED=0 sees a constant read word. Inputs are driven and
//   outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lsu_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, dm_en;
  logic [31:0] resp_rdata, dm_addr, dm_wdata, dm_rdata;

  logic        s_req_valid, s_req_ready, s_resp_valid, s_resp_err, s_dm_en;
  logic [31:0] s_resp_rdata, s_dm_addr, s_dm_wdata, s_dm_rdata;

  lsu_master #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_en(dm_en), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  lsu_master #(.ALLOW_MISALIGNED(1'b0)) u_strict (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
    .resp_err(s_resp_err), .dm_en(s_dm_en), .dm_addr(s_dm_addr),
    .dm_wdata(s_dm_wdata), .dm_rdata(s_dm_rdata)
  );

  assign s_dm_rdata = 32'h8BAD_F00D;

  // Memory model: async read, write on the rising edge.
  logic [31:0] mem [64];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (dm_en) begin
      mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  assign dm_rdata = mem[dm_addr[7:2]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the main instance. Call on a falling edge; returns
  // on the falling edge of the IDLE cycle following the response.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int ens, output logic [31:0] a1, output logic [31:0] a2);
    logic got;
    check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; ens = 0; a1 = 32'h0; a2 = 32'h0; rdata = 32'h0; err = 1'b0; got = 1'b0;
    while (!got && lat <= 8) begin
      if (dm_en) ens++;
      if (lat == 1) a1 = dm_addr;
      if (lat == 2) a2 = dm_addr;
      if (resp_valid) begin
        rdata = resp_rdata; err = resp_err; got = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) lat = 99;
    @(negedge clk);
    check({name, "_pulse"}, {30'b0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic do_strict(input string name, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat);
    int lat, ens;
    logic got;
    logic [31:0] rdata;
    logic err;
    req_we = we; req_size = size; req_unsigned = 1'b0; req_addr = addr;
    req_wdata = 32'hFFFF_FFFF; s_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_req_valid = 1'b0;
    lat = 1; ens = 0; got = 1'b0; rdata = 32'h0; err = 1'b0;
    while (!got && lat <= 8) begin
      if (s_dm_en) ens++;
      if (s_resp_valid) begin
        rdata = s_resp_rdata; err = s_resp_err; got = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) lat = 99;
    check({name, "_rdata"}, rdata, exp_rdata);
    check({name, "_err"},   {31'b0, err}, {31'b0, exp_err});
    check({name, "_lat"},   32'(lat), 32'(exp_lat));
    check({name, "_dm_en"}, 32'(ens), (we && !exp_err) ? 32'd1 : 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ens;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_ens);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_ens = exp_ens;
    return v;
  endfunction

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  initial begin
    vec_t        vecs[$];
    logic [31:0] rdata, a1, a2;
    logic        err;
    int          lat, ens;
    logic        seen;

    //             we    size  uns   addr          wdata         exp_rdata     err  lat ens
    vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0));
    vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 1));
    vecs.push_back(mk(1'b1, SZ_B, 1'b0, 32'h0000_0021, 32'h1234_56AA, 32'h0000_0000, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0020, 32'h0,         32'h1122_AA44, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_B, 1'b0, 32'h0000_0021, 32'h0,         32'hFFFF_FFAA, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_B, 1'b1, 32'h0000_0021, 32'h0,         32'h0000_00AA, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_B, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0044, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_B, 1'b0, 32'h0000_0023, 32'h0,         32'h0000_0011, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_H, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_1122, 1'b0, 2, 0));
    vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'h0000_0033, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, 3, 2));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0030, 32'h0,         32'hD400_0000, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0034, 32'h0,         32'h00A1_B2C3, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0033, 32'h0,         32'hA1B2_C3D4, 1'b0, 3, 0));
    vecs.push_back(mk(1'b0, SZ_X, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1, 0));
    vecs.push_back(mk(1'b1, SZ_X, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0));
    vecs.push_back(mk(1'b1, SZ_H, 1'b0, 32'h0000_0012, 32'h0000_1234, 32'h0000_0000, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, SZ_H, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_1234, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_H, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 0));
    vecs.push_back(mk(1'b1, SZ_H, 1'b0, 32'h0000_0037, 32'hFFFF_7788, 32'h0000_0000, 1'b0, 3, 2));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0034, 32'h0,         32'h88A1_B2C3, 1'b0, 2, 0));
    vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h0000_0038, 32'h0,         32'h0000_0077, 1'b0, 2, 0));
    vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'hFFFF_FFFC, 32'h5A00_0000, 32'h0000_0000, 1'b0, 2, 1));
    vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'h0000_0000, 32'h0000_00C3, 32'h0000_0000, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, SZ_H, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0000_C35A, 1'b0, 3, 0));

    // Reset
    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; s_req_valid = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",      {31'b0, req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata,          32'h0);
    check("rst_resp_err",   {31'b0, resp_err},   32'd0);
    check("rst_dm_en",      {31'b0, dm_en},      32'd0);
    check("rst_dm_addr",    dm_addr,             32'h0);
    check("rst_dm_wdata",   dm_wdata,            32'h0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      do_req(nm, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             rdata, err, lat, ens, a1, a2);
      check({nm, "_rdata"}, rdata, vecs[i].exp_rdata);
      check({nm, "_err"},   {31'b0, err}, {31'b0, vecs[i].exp_err});
      check({nm, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
      check({nm, "_dm_en"}, 32'(ens), 32'(vecs[i].exp_ens));
    end

    // Memory contents written by the table, as seen in the model
    check("mem_10", mem[6'h04], 32'h1234_BEEF);
    check("mem_20", mem[6'h08], 32'h1122_AA44);
    check("mem_30", mem[6'h0C], 32'hD400_0000);
    check("mem_34", mem[6'h0D], 32'h88A1_B2C3);
    check("mem_38", mem[6'h0E], 32'h0000_0077);

    // Wrap-around halfword load: second access must go to word 0
    do_req("wrap", 1'b0, SZ_H, 1'b0, 32'hFFFF_FFFF, 32'h0, rdata, err, lat, ens, a1, a2);
    check("wrap_rdata", rdata, 32'hFFFF_C35A);
    check("wrap_lat",   32'(lat), 32'd3);
    check("wrap_addr0", a1, 32'hFFFF_FFFC);
    check("wrap_addr1", a2, 32'h0000_0000);

    // Reset during ACC0 of a store: write suppressed, no response
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_en_before", {31'b0, dm_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_en_in_rst", {31'b0, dm_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_resp", {31'b0, seen}, 32'd0);
    check("abort_mem", mem[6'h10], 32'h0);
    do_req("abort_ld", 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0, rdata, err, lat, ens, a1, a2);
    check("abort_ld_rdata", rdata, 32'h0);

    // Strict instance: misaligned rejected, aligned accesses still served
    do_strict("strict_ld_h3", 1'b0, SZ_H, 32'h0000_0003, 32'h0, 1'b1, 1);
    do_strict("strict_st_h3", 1'b1, SZ_H, 32'h0000_0003, 32'h0, 1'b1, 1);
    do_strict("strict_ld_w4", 1'b0, SZ_W, 32'h0000_0004, 32'h8BAD_F00D, 1'b0, 2);
    do_strict("strict_ld_h2", 1'b0, SZ_H, 32'h0000_0002, 32'hFFFF_8BAD, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
